// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the instruction-fetch and data-access requesters of
// the core share one single-ported memory bus. Data requests win over fetch
// requests. Only one transaction is outstanding at a time. The winning
// requester gets a one-cycle valid pulse and its read data.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   if_req/if_addr             fetch request in
//   if_rdata/if_valid          fetch response out
//   d_req/d_we/d_be/d_addr/d_wdata  data request in
//   d_rdata/d_valid            data response out
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  registered request to memory
//   mem_gnt/mem_rvalid/mem_rdata              memory handshake and response
//   busy                       FSM is not idle
//   bus_err                    sticky response-timeout flag (MEM_ARB_TIMEOUT_EN only)
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add the TIMEOUT parameter, a
// response watchdog and the bus_err port. Without it, RESP waits forever.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                  bus_err,
`endif
  output logic                  busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                busy_q, busy_d;
  logic                d_elig, f_elig;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
`endif
    // A requester whose valid is pulsing this cycle has already been served
    d_elig = d_req & ~d_valid_q;
    f_elig = if_req & ~if_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (d_elig) begin
          owner_d     = OWN_DATA;
          mem_we_d    = d_we;
          mem_be_d    = d_be;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_req_d   = 1'b1;
          state_d     = ST_REQ;
        end else if (f_elig) begin
          owner_d     = OWN_FETCH;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_req_d   = 1'b1;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        // A response arriving in the same cycle as the grant is ignored
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      ST_RESP: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_FETCH) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Watchdog expiry: complete with a safe value and flag the error
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
          if (owner_q == OWN_FETCH) begin
            if_valid_d = 1'b1;
            if_rdata_d = NOP_INSN;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign busy      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus hand
// sequences for priority, spurious responses, reset abort and watchdog.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[7];
  logic [31:0] model_drdata;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
`else
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
`ifdef MEM_ARB_TIMEOUT_EN
    .bus_err    (bus_err),
`endif
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every valid pulse pops the oldest expected response
  task automatic score(input bit is_data, input logic [31:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_unexpected: valid pulse data=%0d rdata %h with nothing expected", is_data, act);
    end else begin
      e = exp_q.pop_front();
      chk("sb_owner", 32'(is_data), 32'(e.is_data));
      chk("sb_rdata", act, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (if_valid === 1'b1) score(1'b0, if_rdata);
      if (d_valid === 1'b1) score(1'b1, d_rdata);
    end
  end

  task automatic wait_mem_req();
    for (int i = 0; i < 40; i++) begin
      if (mem_req === 1'b1) break;
      @(negedge clk);
    end
  endtask

  // Memory side of one transaction; returns with the valid pulse visible
  task automatic serve(input logic [31:0] ea, input bit ewe, input logic [3:0] ebe,
                       input logic [31:0] ewd, input int gnt_dly, input int rv_dly,
                       input bit spur, input logic [31:0] rdata, input bit is_data,
                       output int vcyc);
    vcyc = -1;
    wait_mem_req();
    if (mem_req !== 1'b1) begin
      chk("mem_req_wait", 32'(mem_req), 32'd1);
      return;
    end
    chk("mem_addr", mem_addr, ea);
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_be", 32'(mem_be), 32'(ebe));
    if (is_data) chk("mem_wdata", mem_wdata, ewd);
    chk("busy_req", 32'(busy), 32'd1);
    for (int k = 0; k < gnt_dly; k++) begin
      mem_rvalid = spur;
      mem_rdata  = 32'h1111_1111;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, ea);
      chk("we_be_hold", 32'({mem_we, mem_be}), 32'({ewe, ebe}));
      if (is_data) chk("wdata_hold", mem_wdata, ewd);
      chk("no_valid_in_req", 32'({if_valid, d_valid}), 32'd0);
    end
    mem_gnt    = 1'b1;
    mem_rvalid = spur;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    chk("mem_req_drop", 32'(mem_req), 32'd0);
    chk("busy_resp", 32'(busy), 32'd1);
    for (int k = 0; k < rv_dly; k++) begin
      @(negedge clk);
      chk("resp_wait", 32'({busy, if_valid, d_valid}), 32'b100);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    vcyc = cyc;
    chk("valid_pulse", 32'({if_valid, d_valid}), is_data ? 32'b01 : 32'b10);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   vc;
    e.is_data = v.is_data;
    if (v.is_data) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_be    = v.be;
      d_addr  = v.addr;
      d_wdata = v.wdata;
      if (!v.we) model_drdata = v.rdata;
      e.rdata = model_drdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
      e.rdata = v.rdata;
    end
    exp_q.push_back(e);
    serve(v.addr, v.is_data ? v.we : 1'b0, v.is_data ? v.be : 4'hF, v.wdata,
          v.gnt_dly, v.rv_dly, 1'b0, v.rdata, v.is_data, vc);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    chk("pulse_end", 32'({if_valid, d_valid}), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   vd;
    int   vf;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_drdata = '0;

    //         data we  be     addr          wdata         rdata         gnt rv
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h0050_0093, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'h0,        32'hDEAD_BEEF, 1, 0};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hAABB_CCDD, 32'h7777_7777, 4, 0};
    vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0,        32'h00A0_0113, 2, 3};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0,        32'h1234_5678, 0, 1};
    vecs[5] = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFF, 0, 0};
    vecs[6] = '{1'b0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFF, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valids", 32'({if_valid, d_valid}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we_be", 32'({mem_we, mem_be}), 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("rst_bus_err", 32'(bus_err), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Simultaneous requests: data first, fetch straight after
    if_req = 1'b1; if_addr = 32'h0000_0108;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_2000; d_wdata = 32'h0;
    model_drdata = 32'hCAFE_F00D;
    e.is_data = 1'b1; e.rdata = 32'hCAFE_F00D; exp_q.push_back(e);
    e.is_data = 1'b0; e.rdata = 32'h0010_0193; exp_q.push_back(e);
    serve(32'h0000_2000, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b1, vd);
    d_req = 1'b0;
    @(negedge clk);
    chk("sim_d_pulse_end", 32'(d_valid), 32'd0);
    serve(32'h0000_0108, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0010_0193, 1'b0, vf);
    if_req = 1'b0;
    chk("sim_d_before_if", 32'(vf - vd), 32'd3);
    @(negedge clk);

    // Spurious rvalid in IDLE, then a stalled grant with spurious rvalid in REQ
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("spur_idle", 32'({busy, mem_req, if_valid, d_valid}), 32'd0);
    @(negedge clk);
    chk("spur_idle2", 32'({busy, mem_req, if_valid, d_valid}), 32'd0);
    chk("spur_if_rdata_hold", if_rdata, 32'h0010_0193);
    if_req = 1'b1; if_addr = 32'h0000_010C;
    e.is_data = 1'b0; e.rdata = 32'h0020_8233; exp_q.push_back(e);
    serve(32'h0000_010C, 1'b0, 4'hF, 32'h0, 3, 0, 1'b1, 32'h0020_8233, 1'b0, vf);
    if_req = 1'b0;
    @(negedge clk);

    // Reset while waiting for the response
    if_req = 1'b1; if_addr = 32'h0000_0110;
    @(negedge clk);
    wait_mem_req();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("abort_in_resp", 32'(busy), 32'd1);
    rst = 1'b0; if_req = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_if_rdata", if_rdata, 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    model_drdata = '0;
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid", 32'({busy, if_valid, d_valid}), 32'd0);
    @(negedge clk);
    chk("late_rvalid2", 32'({busy, if_valid, d_valid}), 32'd0);
    run_vec('{1'b0, 1'b0, 4'hF, 32'h0000_0114, 32'h0, 32'h0030_0313, 0, 0});

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no response for TIMEOUT=8 cycles in RESP
    begin
      int resp_cycles;
      resp_cycles = 0;
      chk("pre_bus_err", 32'(bus_err), 32'd0);
      e.is_data = 1'b0; e.rdata = 32'h0000_0013; exp_q.push_back(e);
      if_req = 1'b1; if_addr = 32'h0000_0200;
      @(negedge clk);
      wait_mem_req();
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      for (int k = 0; k < 30; k++) begin
        if (!(busy === 1'b1 && if_valid !== 1'b1)) break;
        resp_cycles++;
        @(negedge clk);
      end
      chk("to_resp_cycles", 32'(resp_cycles), 32'd8);
      chk("to_if_valid", 32'(if_valid), 32'd1);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      if_req = 1'b0;
      @(negedge clk);
      run_vec('{1'b1, 1'b0, 4'hF, 32'h0000_2008, 32'h0, 32'h0BAD_F00D, 0, 0});
      chk("to_bus_err_sticky", 32'(bus_err), 32'd1);
    end
`endif

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
